// File: rtl/sa_operand_feeder.sv
// rtl/sa_operand_feeder.sv - operand sequencer feeding X columns and W rows into a systolic array
//
// Purpose:
//   Holds one X matrix (S x K) and one W matrix (K x C). On a run request it
//   pulses the array start flag, then presents X column K-1-sel and W row
//   K-1-sel, advancing sel on each PE shift strobe. Completion is signalled
//   when the array raises its output valid.
//
// Ports:
//   I_CLK, I_RST_N              clock, asynchronous active-low reset
//   I_XLD_VLD/ADDR/DATA         X row load (row of K elements)
//   I_WLD_VLD/ADDR/DATA         W row load (row of C elements)
//   I_RUN                       start request, level sampled in IDLE
//   I_PE_SHIFT, I_OUT_VLD       handshake from the array
//   O_START_FLAG                one-cycle start pulse to the array
//   O_X, O_W                    current operand column / row
//   O_BUSY, O_DONE, O_LD_DROP   status

module sa_operand_feeder #(
    parameter int D_W = 16,
    parameter int S   = 16,
    parameter int C   = 16,
    parameter int K   = 16,
    localparam int SA_W = (S > 1) ? $clog2(S) : 1,
    localparam int KA_W = $clog2(K)
) (
    input  logic                I_CLK,
    input  logic                I_RST_N,
    input  logic                I_XLD_VLD,
    input  logic [SA_W-1:0]     I_XLD_ADDR,
    input  logic [K*D_W-1:0]    I_XLD_DATA,
    input  logic                I_WLD_VLD,
    input  logic [KA_W-1:0]     I_WLD_ADDR,
    input  logic [C*D_W-1:0]    I_WLD_DATA,
    input  logic                I_RUN,
    input  logic                I_PE_SHIFT,
    input  logic                I_OUT_VLD,
    output logic                O_START_FLAG,
    output logic [S*D_W-1:0]    O_X,
    output logic [C*D_W-1:0]    O_W,
    output logic                O_BUSY,
    output logic                O_DONE,
    output logic                O_LD_DROP
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_STREAM = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    localparam logic [KA_W-1:0] SEL_MAX = KA_W'(K - 1);

    state_t              state;
    logic [KA_W-1:0]     sel;
    logic [K*D_W-1:0]    x_mem [S];
    logic [C*D_W-1:0]    w_mem [K];
    logic [KA_W-1:0]     sel_rev;
    logic                load_ok;
    logic                load_req;

    assign load_ok  = (state == ST_IDLE);
    assign load_req = I_XLD_VLD | I_WLD_VLD;

    // Operand buffers; cleared by reset so a reset mid-run leaves no stale data.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            for (int i = 0; i < S; i++) x_mem[i] <= '0;
            for (int k = 0; k < K; k++) w_mem[k] <= '0;
        end else begin
            if (load_ok && I_XLD_VLD && (32'(I_XLD_ADDR) < S))
                x_mem[I_XLD_ADDR] <= I_XLD_DATA;
            if (load_ok && I_WLD_VLD && (32'(I_WLD_ADDR) < K))
                w_mem[I_WLD_ADDR] <= I_WLD_DATA;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state        <= ST_IDLE;
            sel          <= '0;
            O_START_FLAG <= 1'b0;
            O_BUSY       <= 1'b0;
            O_DONE       <= 1'b0;
            O_LD_DROP    <= 1'b0;
        end else begin
            O_START_FLAG <= 1'b0;
            O_DONE       <= 1'b0;
            if (!load_ok && load_req)
                O_LD_DROP <= 1'b1;
            case (state)
                ST_IDLE: begin
                    sel <= '0;
                    if (I_RUN) begin
                        state        <= ST_START;
                        O_START_FLAG <= 1'b1;
                        O_BUSY       <= 1'b1;
                        O_LD_DROP    <= 1'b0;
                    end
                end
                ST_START: begin
                    // Array sees the start pulse this cycle; shift and
                    // output-valid from it are not expected yet.
                    sel   <= '0;
                    state <= ST_STREAM;
                end
                ST_STREAM: begin
                    // Completion has priority over a coincident shift.
                    if (I_OUT_VLD) begin
                        state  <= ST_IDLE;
                        sel    <= '0;
                        O_BUSY <= 1'b0;
                        O_DONE <= 1'b1;
                    end else if (I_PE_SHIFT) begin
                        if (sel == SEL_MAX)
                            state <= ST_WAIT;
                        else
                            sel <= sel + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (I_OUT_VLD) begin
                        state  <= ST_IDLE;
                        sel    <= '0;
                        O_BUSY <= 1'b0;
                        O_DONE <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    sel    <= '0;
                    O_BUSY <= 1'b0;
                end
            endcase
        end
    end

    // Operands are fed last reduction index first, so sel counts up while
    // the buffer index counts down.
    assign sel_rev = SEL_MAX - sel;

    always_comb begin
        O_X = '0;
        for (int i = 0; i < S; i++)
            O_X[i*D_W +: D_W] = x_mem[i][sel_rev*D_W +: D_W];
        O_W = w_mem[sel_rev];
    end

endmodule
